// File: rtl/aes_pkg.sv
// Shared AES types, constants and word-level helpers for the key schedule
// and the round datapath.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [31:0] word_t;

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 occupies the top byte, so the bit offset of entry n is (255-n)*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_ofs;

  assign w_ofs  = {~i_byte, 3'b000};
  assign o_byte = SBOX[w_ofs +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..10 one per cycle
// after a start pulse and keeps all of them in a readable store.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rk_valid_o,
  output logic [3:0]       rk_round_o,
  output logic [KEY_W-1:0] rk_o,
  input  logic [3:0]       rd_idx_i,
  output logic [KEY_W-1:0] rd_key_o
);

  if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
    $error("aes_key_expand supports only AES-128 (NR=10, KEY_W=128)");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);
  localparam logic [3:0] PREV_RND = 4'(NR - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_busy, r_done, r_valid;
  logic [3:0]        r_round;
  logic [7:0]        r_rcon;
  logic [KEY_W-1:0]  r_key_lat, r_rk, r_rd;
  logic [KEY_W-1:0]  r_store [0:NR];
  logic              w_accept, w_load, w_step, w_last;
  word_t             w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_t;
  word_t             w_n0, w_n1, w_n2, w_n3;
  logic [KEY_W-1:0]  w_next;

  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
  assign w_rot = rot_word(w_w3);

  for (genvar g = 0; g < NK; g++) begin : g_sub
    aes_sbox u_sbox (.i_byte(w_rot[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
  end

  assign w_t    = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0   = w_w0 ^ w_t;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The IDLE cycle right after round 10 still has busy high, so no restart there.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i && !r_busy) w_state_nxt = LOAD; else w_state_nxt = IDLE;
      LOAD:    w_state_nxt = EXPAND;
      EXPAND:  if (r_round == PREV_RND) w_state_nxt = IDLE; else w_state_nxt = EXPAND;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE:    w_accept = start_i && !r_busy;
      LOAD:    w_load   = 1'b1;
      EXPAND:  w_step   = 1'b1;
      default: w_accept = 1'b0;
    endcase
    w_last = w_step && (r_round == PREV_RND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_round   <= 4'd0;
      r_rcon    <= RCON_INIT;
      r_key_lat <= '0;
      r_rk      <= '0;
      r_rd      <= '0;
      for (int i = 0; i <= NR; i++) r_store[i] <= '0;
    end else begin
      if (w_accept) r_key_lat <= key_i;
      r_busy  <= w_load | w_step;
      r_valid <= w_load | w_step;
      r_done  <= w_last;
      if (w_load) begin
        r_rk       <= r_key_lat;
        r_round    <= 4'd0;
        r_rcon     <= RCON_INIT;
        r_store[0] <= r_key_lat;
      end else if (w_step) begin
        r_rk                   <= w_next;
        r_round                <= r_round + 4'd1;
        r_rcon                 <= xtime(r_rcon);
        r_store[r_round + 4'd1] <= w_next;
      end
      // Non-blocking read: a same-edge write is seen one cycle later.
      r_rd <= (rd_idx_i <= LAST_RND) ? r_store[rd_idx_i] : '0;
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign rk_valid_o = r_valid;
  assign rk_round_o = r_round;
  assign rk_o       = r_rk;
  assign rd_key_o   = r_rd;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: a FIPS-197 word-level model with an
// S-box derived from GF(2^8) inversion supplies the expected key stream.
module tb_aes_key_expand;

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [3:0]   rd_idx_i = 4'd0;
  logic         busy_o, done_o, rk_valid_o;
  logic [3:0]   rk_round_o;
  logic [127:0] rk_o, rd_key_o;

  aes_key_expand #(.NR(10), .KEY_W(128)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i),
    .busy_o(busy_o), .done_o(done_o), .rk_valid_o(rk_valid_o),
    .rk_round_o(rk_round_o), .rk_o(rk_o), .rd_idx_i(rd_idx_i), .rd_key_o(rd_key_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
    logic         done;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_pass = 0, n_total = 0;
  int           cyc = 0, n_valid = 0, n_done = 0;
  logic [127:0] obs [16];
  logic [7:0]   sbox_m [256];
  logic [127:0] model_rk [11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      for (int k = 1; k <= 4; k++) s = s ^ 8'((inv << k) | (inv >> (8 - k)));
      sbox_m[x] = s;
    end
  endtask

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    int rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ (32'(rc) << 24);
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Monitor: every valid cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rk_valid_o) begin
      n_valid++;
      obs[rk_round_o] = rk_o;
      if (exp_q.size() == 0) begin
        chk("unexpected_rk", {124'd0, rk_round_o}, 128'hffff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rk_round", {124'd0, rk_round_o}, {124'd0, mon_e.round});
        chk("rk_key", rk_o, mon_e.key);
        chk("rk_done", {127'd0, done_o}, {127'd0, mon_e.done});
        chk("rk_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
    if (done_o) n_done++;
  end

  // Issue a start that must be accepted; push the whole expected stream.
  task automatic start_expand(input logic [127:0] k);
    int base;
    exp_t e;
    expand(k);
    base = cyc + 1;
    for (int r = 0; r < 11; r++) begin
      e.round = 4'(r);
      e.key   = model_rk[r];
      e.done  = (r == 10);
      e.cyc   = base + 1 + r;
      exp_q.push_back(e);
    end
    key_i = k;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_ignored(input logic [127:0] k);
    key_i = k;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_round(input int r);
    int k = 0;
    while (!(rk_valid_o && rk_round_o == 4'(r)) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 40) chk("wait_round_timeout", 128'(k), 128'(r));
  endtask

  initial begin
    int v0, d0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {127'd0, busy_o}, 128'd0);
    chk("rst_done", {127'd0, done_o}, 128'd0);
    chk("rst_valid", {127'd0, rk_valid_o}, 128'd0);
    chk("rst_round", {124'd0, rk_round_o}, 128'd0);
    chk("rst_rk", rk_o, 128'd0);
    chk("rst_rd", rd_key_o, 128'd0);

    // FIPS-197 A.1 with busy/done timing.
    start_expand(A1_KEY);
    @(posedge clk); #1;
    chk("a1_busy_load", {127'd0, busy_o}, 128'd1);
    wait_round(10);
    chk("a1_busy_done", {127'd0, busy_o}, 128'd1);
    chk("a1_done", {127'd0, done_o}, 128'd1);
    @(posedge clk); #1;
    chk("a1_busy_after", {127'd0, busy_o}, 128'd0);
    chk("a1_done_after", {127'd0, done_o}, 128'd0);
    chk("a1_rk_hold", rk_o, A1_R10);
    chk("a1_r0", obs[0], A1_KEY);
    chk("a1_r1", obs[1], A1_R1);
    chk("a1_r10", obs[10], A1_R10);

    rd_idx_i = 4'd1;  @(posedge clk); #1; chk("rd_1", rd_key_o, A1_R1);
    rd_idx_i = 4'd10; @(posedge clk); #1; chk("rd_10", rd_key_o, A1_R10);
    rd_idx_i = 4'd12; @(posedge clk); #1; chk("rd_12", rd_key_o, 128'd0);
    rd_idx_i = 4'd0;  @(posedge clk); #1; chk("rd_0", rd_key_o, A1_KEY);

    // Zero key.
    v0 = n_valid;
    start_expand(128'd0);
    wait_round(10);
    @(posedge clk); #1;
    chk("zero_r1", obs[1], Z_R1);
    chk("zero_r10", obs[10], Z_R10);
    chk("zero_pulses", 128'(n_valid - v0), 128'd11);

    // Starts while busy are ignored; restart right after done is accepted.
    start_expand(A1_KEY);
    wait_round(3);
    pulse_ignored(128'd0);
    wait_round(10);
    pulse_ignored(128'd0);
    start_expand(128'd0);
    wait_round(0);
    rd_idx_i = 4'd1;
    @(posedge clk); #1; chk("rd_same_cycle_old", rd_key_o, A1_R1);
    @(posedge clk); #1; chk("rd_next_cycle_new", rd_key_o, Z_R1);
    wait_round(10);
    @(posedge clk); #1;

    // Reset mid-expansion.
    start_expand(A1_KEY);
    wait_round(5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    d0 = n_done;
    chk("mid_rst_busy", {127'd0, busy_o}, 128'd0);
    chk("mid_rst_done", {127'd0, done_o}, 128'd0);
    chk("mid_rst_valid", {127'd0, rk_valid_o}, 128'd0);
    chk("mid_rst_round", {124'd0, rk_round_o}, 128'd0);
    chk("mid_rst_rk", rk_o, 128'd0);
    chk("mid_rst_rd", rd_key_o, 128'd0);
    repeat (15) @(posedge clk);
    #1 chk("mid_rst_no_done", 128'(n_done - d0), 128'd0);
    for (int i = 0; i <= 10; i++) begin
      rd_idx_i = 4'(i);
      @(posedge clk); #1;
      chk("mid_rst_store", rd_key_o, 128'd0);
    end

    start_expand(A1_KEY);
    wait_round(10);
    chk("post_rst_r10", rk_o, A1_R10);
    @(posedge clk); #1;

    // Random keys against the model.
    for (int n = 0; n < 5; n++) begin
      start_expand({$urandom, $urandom, $urandom, $urandom});
      wait_round(10);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key schedule that produces round keys 0..10 for the round-key XOR stage, which sits directly downstream.
- Generates one 128-bit round key per clock after a start pulse and streams each key with a valid flag and its round index.
- Keeps all 11 keys in an internal store, so the datapath can re-read any round key without re-expanding.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.
- KEY_W, 128, cipher key and round key width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle request to expand key_i; sampled only when busy_o=0.
- key_i  in  128  cipher key. w0 = key_i[127:96] (FIPS-197 byte order, byte0 = [127:120]).
- busy_o  out  1  expansion in progress.
- done_o  out  1  one-cycle pulse with round 10.
- rk_valid_o  out  1  rk_o/rk_round_o valid this cycle.
- rk_round_o  out  4  round index 0..10 of rk_o.
- rk_o  out  128  streamed round key.
- rd_idx_i  in  4  store read index.
- rd_key_o  out  128  registered store read data.

Behaviour:
- Reset (rst=1 at a clk edge): busy_o=0, done_o=0, rk_valid_o=0, rk_round_o=0, rk_o=0, rd_key_o=0, all 11 store entries=0, FSM=IDLE, rcon=8'h01. Reset has priority over everything, including mid-expansion; a partial expansion is discarded and no done_o is produced.
- FSM states:
  - IDLE -> LOAD on start_i=1.
  - LOAD (1 cycle): rk_o=key_i latched at start, round 0, store[0] written -> EXPAND.
  - EXPAND: rounds 1..10, one per cycle -> IDLE after round 10.
- Timing, start sampled at edge T:
  - Edge T+1: rk_valid_o=1, rk_round_o=0.
  - Edge T+1+r: round r, r=1..10.
  - done_o=1 only in the cycle holding round 10 (after edge T+11).
  - busy_o=1 from after T+1 through after T+11; 0 after T+12.
  - Total latency start -> round 10 = 11 cycles.
  - The rk_* outputs hold their last value when rk_valid_o=0.
- start_i while busy_o=1 is ignored; the in-flight key is unaffected. A start in the done_o cycle is ignored (busy_o still 1). Earliest accepted restart is the cycle after done_o.
- key_i is captured only at the accepting edge; later changes have no effect.
- Round r from round r-1 (words w0..w3):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord: [a,b,c,d] -> [b,c,d,a].
  - rcon sequence 01,02,04,08,10,20,40,80,1B,36 via GF(2^8) xtime; reset to 01 at LOAD.
- Store:
  - store[r] is written on the same edge that presents round r on rk_o.
  - Entries from a previous expansion persist until overwritten.
- Read port:
  - rd_key_o <= store[rd_idx_i] every cycle; latency 1.
  - rd_idx_i > 10 returns 0.
  - A read of index r in the same cycle store[r] is written returns the old value; the new value appears the following cycle.

Decomposition:
- Package aes_pkg holds:
  - constants NR=10 and NK=4;
  - a 32-bit word typedef;
  - functions rot_word and xtime;
  - the RCON_INIT constant.
- The FSM state enum (IDLE, LOAD, EXPAND) is local to the module.
- Sub-module aes_sbox: combinational 8-bit forward S-box lookup, instantiated 4x for SubWord. It is shared later with the SubBytes stage.

Test Plan:
- FIPS-197 A.1:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - Round 0 equals the key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done_o occurs exactly 11 cycles after the start edge, coincident with round 10.
- Zero key:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Exactly 11 rk_valid_o pulses with rk_round_o 0..10 in order.
- Start while busy:
  - Stimulus: A.1 key start, then start_i with the zero key at rounds 3 and 10.
  - Output stream is the unchanged A.1 sequence; a zero-key start the cycle after done_o is accepted.
- Reset mid-expansion:
  - Stimulus: rst=1 at round 5.
  - Next cycle: all outputs 0, busy_o=0, no done_o; every rd_idx_i 0..10 reads 0.
  - A subsequent A.1 start yields the correct round 10.
- Read port:
  - After A.1 completes, set rd_idx_i=1 -> next cycle rd_key_o=a0fafe17...7605.
  - rd_idx_i=10 -> d014f9a8...0ca6.
  - rd_idx_i=12 -> 0.
  - Same-cycle read of the index being written returns the prior expansion's value.
